// File: rtl/difftest_pkg.sv
// Shared defaults and the writeback entry layout
// for the difftest integer writeback queue.
package difftest_pkg;

  localparam int DEF_NUM_PORTS = 2;
  localparam int DEF_ADDR_W    = 5;
  localparam int DEF_DATA_W    = 64;
  localparam int DEF_DEPTH     = 8;
  localparam int DEF_SKIP_ZERO = 1;
  localparam int COREID_W      = 8;
  localparam int DROP_W        = 16;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0] address;
    logic [DEF_DATA_W-1:0] data;
    logic [COREID_W-1:0]   coreid;
  } wb_entry_t;

endpackage

// File: rtl/difftest_wb_fifo.sv
// Circular buffer taking up to NUM_PORTS compacted
// writes per edge and releasing one entry per edge.
module difftest_wb_fifo #(
  parameter int EW        = 77,
  parameter int DEPTH     = 8,
  parameter int NUM_PORTS = 2,
  parameter int PW        = $clog2(DEPTH),
  parameter int CW        = PW + 1,
  parameter int PCW       = $clog2(NUM_PORTS + 1)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [PCW-1:0]          push_cnt,
  input  logic [NUM_PORTS*EW-1:0] wdata,
  input  logic                    pop,
  output logic [EW-1:0]           head,
  output logic [CW-1:0]           count
);

  logic [EW-1:0] mem_q [DEPTH];
  logic [EW-1:0] mem_d [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;

  always_comb begin
    mem_d = mem_q;
    for (int j = 0; j < NUM_PORTS; j++) begin
      if (j < int'(push_cnt)) begin
        mem_d[wptr_q + PW'(j)] = wdata[j*EW +: EW];
      end
    end
    wptr_d  = wptr_q + PW'(push_cnt);
    rptr_d  = rptr_q + PW'(pop);
    count_d = count_q + CW'(push_cnt) - CW'(pop);
  end

  // Storage needs no reset; occupancy gates visibility.
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  assign head  = mem_q[rptr_q];
  assign count = count_q;

endmodule

// File: rtl/difftest_int_wb_queue.sv
// Collects integer writebacks from several ports into
// one ordered queue, accounting for dropped entries.
module difftest_int_wb_queue
  import difftest_pkg::*;
#(
  parameter int NUM_PORTS = DEF_NUM_PORTS,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int SKIP_ZERO = DEF_SKIP_ZERO
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [NUM_PORTS-1:0]        in_valid,
  input  logic [NUM_PORTS*ADDR_W-1:0] in_address,
  input  logic [NUM_PORTS*DATA_W-1:0] in_data,
  input  logic [7:0]                  coreid,
  input  logic                        clear_ovf,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [ADDR_W-1:0]           out_address,
  output logic [DATA_W-1:0]           out_data,
  output logic [7:0]                  out_coreid,
  output logic [$clog2(DEPTH):0]      count,
  output logic                        overflow,
  output logic [15:0]                 drop_cnt
);

  localparam int EW  = ADDR_W + DATA_W + COREID_W;
  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = PW + 1;
  localparam int PCW = $clog2(NUM_PORTS + 1);

  logic                    pop;
  logic [PCW-1:0]          push_cnt;
  logic [NUM_PORTS*EW-1:0] wdata;
  logic [EW-1:0]           head;
  logic [CW-1:0]           count_w;
  logic [16:0]             n_drop;
  logic [16:0]             drop_sum;
  logic                    ovf_q, ovf_d;
  logic [15:0]             drop_q, drop_d;

  assign out_valid = (count_w != '0);
  assign pop       = out_valid & out_ready;

  // Lowest-index eligible ports fill free slots first.
  always_comb begin
    int space;
    int k;
    logic elig;
    space  = DEPTH - int'(count_w) + int'(pop);
    k      = 0;
    n_drop = '0;
    wdata  = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      elig = in_valid[i] &&
             ((SKIP_ZERO == 0) ||
              (in_address[i*ADDR_W +: ADDR_W] != '0));
      if (elig) begin
        if (k < space) begin
          wdata[k*EW +: EW] = {in_address[i*ADDR_W +: ADDR_W],
                               in_data[i*DATA_W +: DATA_W],
                               coreid};
          k = k + 1;
        end else begin
          n_drop = n_drop + 17'd1;
        end
      end
    end
    push_cnt = PCW'(k);
  end

  // A drop in the clearing cycle restarts the count at it.
  always_comb begin
    ovf_d    = clear_ovf ? 1'b0 : ovf_q;
    drop_sum = {1'b0, (clear_ovf ? 16'd0 : drop_q)} + n_drop;
    drop_d   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    if (n_drop != '0) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ovf_q  <= 1'b0;
      drop_q <= '0;
    end else begin
      ovf_q  <= ovf_d;
      drop_q <= drop_d;
    end
  end

  difftest_wb_fifo #(
    .EW        (EW),
    .DEPTH     (DEPTH),
    .NUM_PORTS (NUM_PORTS)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .push_cnt (push_cnt),
    .wdata    (wdata),
    .pop      (pop),
    .head     (head),
    .count    (count_w)
  );

  assign count       = count_w;
  assign overflow    = ovf_q;
  assign drop_cnt    = drop_q;
  assign out_address = out_valid ? head[EW-1 -: ADDR_W] : '0;
  assign out_data    = out_valid ? head[COREID_W +: DATA_W] : '0;
  assign out_coreid  = out_valid ? head[COREID_W-1:0] : '0;

endmodule

// File: tb/tb_difftest_int_wb_queue.sv
// Directed bench for difftest_int_wb_queue at default
// parameters, one task per scenario.
module tb_difftest_int_wb_queue;
  import difftest_pkg::*;

  localparam int NP = 2;
  localparam int AW = 5;
  localparam int DW = 64;

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic [NP-1:0]   in_valid;
  logic [NP*AW-1:0] in_address;
  logic [NP*DW-1:0] in_data;
  logic [7:0]      coreid;
  logic            clear_ovf;
  logic            out_valid;
  logic            out_ready;
  logic [AW-1:0]   out_address;
  logic [DW-1:0]   out_data;
  logic [7:0]      out_coreid;
  logic [3:0]      count;
  logic            overflow;
  logic [15:0]     drop_cnt;

  int checks   = 0;
  int failures = 0;

  difftest_int_wb_queue dut (
    .clock       (clock),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_address  (in_address),
    .in_data     (in_data),
    .coreid      (coreid),
    .clear_ovf   (clear_ovf),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_address (out_address),
    .out_data    (out_data),
    .out_coreid  (out_coreid),
    .count       (count),
    .overflow    (overflow),
    .drop_cnt    (drop_cnt)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    in_valid   = '0;
    in_address = '0;
    in_data    = '0;
    clear_ovf  = 1'b0;
  endtask

  task automatic drive2(input logic [1:0] v,
                        input logic [AW-1:0] a0,
                        input logic [AW-1:0] a1,
                        input logic [DW-1:0] d0,
                        input logic [DW-1:0] d1);
    in_valid   = v;
    in_address = {a1, a0};
    in_data    = {d1, d0};
  endtask

  task automatic test_reset();
    idle();
    out_ready = 1'b0;
    coreid    = 8'h11;
    reset     = 1'b0;
    #12;
    checks++;
    if (count !== 4'd0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_count got=%0d/%b exp=0/0",
               count, out_valid);
    end
    checks++;
    if (overflow !== 1'b0 || drop_cnt !== 16'd0) begin
      failures++;
      $display("FAIL reset_ovf got=%b/%0d exp=0/0",
               overflow, drop_cnt);
    end
    checks++;
    if (out_address !== '0 || out_data !== '0 ||
        out_coreid !== '0) begin
      failures++;
      $display("FAIL reset_out got=%h/%h/%h exp=0",
               out_address, out_data, out_coreid);
    end
    @(negedge clock);
    reset = 1'b1;
    step();
  endtask

  task automatic test_order();
    out_ready = 1'b1;
    coreid    = 8'h22;
    drive2(2'b11, 5'd3, 5'd7, 64'hAAA3, 64'hAAA7);
    step();
    idle();
    checks++;
    if (count !== 4'd2 || out_address !== 5'd3) begin
      failures++;
      $display("FAIL order_first got=%0d/%0d exp=2/3",
               count, out_address);
    end
    checks++;
    if (out_coreid !== 8'h22 || out_data !== 64'hAAA3) begin
      failures++;
      $display("FAIL order_fields got=%h/%h exp=22/aaa3",
               out_coreid, out_data);
    end
    step();
    checks++;
    if (count !== 4'd1 || out_address !== 5'd7) begin
      failures++;
      $display("FAIL order_second got=%0d/%0d exp=1/7",
               count, out_address);
    end
    step();
    checks++;
    if (count !== 4'd0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL order_empty got=%0d/%b exp=0/0",
               count, out_valid);
    end
  endtask

  task automatic test_skip_zero();
    out_ready = 1'b0;
    drive2(2'b01, 5'd0, 5'd0, 64'h1, 64'h2);
    step();
    idle();
    checks++;
    if (count !== 4'd0 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL skip_zero got=%0d/%b exp=0/0",
               count, overflow);
    end
    drive2(2'b11, 5'd0, 5'd9, 64'h5, 64'h99);
    step();
    idle();
    checks++;
    if (count !== 4'd1 || out_address !== 5'd9 ||
        out_data !== 64'h99) begin
      failures++;
      $display("FAIL skip_mixed got=%0d/%0d/%h exp=1/9/99",
               count, out_address, out_data);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_overflow();
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      drive2(2'b11, 5'd1, 5'd2,
             64'h100 + 64'(c), 64'h200 + 64'(c));
      step();
    end
    idle();
    checks++;
    if (count !== 4'd8 || drop_cnt !== 16'd2 ||
        overflow !== 1'b1) begin
      failures++;
      $display("FAIL ovf_fill got=%0d/%0d/%b exp=8/2/1",
               count, drop_cnt, overflow);
    end
    checks++;
    if (out_data !== 64'h100) begin
      failures++;
      $display("FAIL ovf_head got=%h exp=100", out_data);
    end
    out_ready = 1'b1;
    drive2(2'b11, 5'd1, 5'd2, 64'h300, 64'h301);
    step();
    idle();
    out_ready = 1'b0;
    checks++;
    if (count !== 4'd8 || drop_cnt !== 16'd3) begin
      failures++;
      $display("FAIL full_pop got=%0d/%0d exp=8/3",
               count, drop_cnt);
    end
    checks++;
    if (out_data !== 64'h200) begin
      failures++;
      $display("FAIL full_head got=%h exp=200", out_data);
    end
    drive2(2'b11, 5'd1, 5'd2, 64'h400, 64'h401);
    clear_ovf = 1'b1;
    step();
    idle();
    checks++;
    if (overflow !== 1'b1 || drop_cnt !== 16'd2) begin
      failures++;
      $display("FAIL clr_drop got=%b/%0d exp=1/2",
               overflow, drop_cnt);
    end
    clear_ovf = 1'b1;
    step();
    idle();
    checks++;
    if (overflow !== 1'b0 || drop_cnt !== 16'd0) begin
      failures++;
      $display("FAIL clr_only got=%b/%0d exp=0/0",
               overflow, drop_cnt);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) step();
    out_ready = 1'b0;
    checks++;
    if (count !== 4'd0) begin
      failures++;
      $display("FAIL ovf_drain got=%0d exp=0", count);
    end
  endtask

  task automatic test_wrap();
    wb_entry_t q[$];
    wb_entry_t e;
    logic      rdy;
    int        bound;
    for (int i = 0; i < 20; i++) begin
      rdy        = (i % 3 != 2);
      out_ready  = rdy;
      e.address  = 5'((i % 31) + 1);
      e.data     = {32'hA5A5_0000, 32'(i)};
      e.coreid   = 8'(i + 16);
      coreid     = e.coreid;
      in_valid   = (i % 2 == 0) ? 2'b01 : 2'b10;
      in_address = {e.address, e.address};
      in_data    = {e.data, e.data};
      checks++;
      if (out_valid !== (q.size() != 0)) begin
        failures++;
        $display("FAIL wrap_valid i=%0d got=%b exp=%b",
                 i, out_valid, q.size() != 0);
      end
      if (q.size() != 0) begin
        checks++;
        if (out_address !== q[0].address ||
            out_data !== q[0].data ||
            out_coreid !== q[0].coreid) begin
          failures++;
          $display("FAIL wrap_head i=%0d got=%h/%h/%h exp=%h/%h/%h",
                   i, out_address, out_data, out_coreid,
                   q[0].address, q[0].data, q[0].coreid);
        end
      end
      step();
      if (q.size() != 0 && rdy) void'(q.pop_front());
      q.push_back(e);
      checks++;
      if (count !== 4'(q.size())) begin
        failures++;
        $display("FAIL wrap_count i=%0d got=%0d exp=%0d",
                 i, count, q.size());
      end
    end
    idle();
    out_ready = 1'b1;
    bound = 0;
    while (q.size() != 0 && bound < 30) begin
      checks++;
      if (out_valid !== 1'b1 || out_address !== q[0].address ||
          out_data !== q[0].data) begin
        failures++;
        $display("FAIL wrap_drain got=%b/%h/%h exp=1/%h/%h",
                 out_valid, out_address, out_data,
                 q[0].address, q[0].data);
      end
      step();
      void'(q.pop_front());
      bound++;
    end
    out_ready = 1'b0;
    checks++;
    if (count !== 4'd0 || bound >= 30) begin
      failures++;
      $display("FAIL wrap_end got=%0d bound=%0d exp=0",
               count, bound);
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    coreid    = 8'h5C;
    drive2(2'b11, 5'd4, 5'd5, 64'h40, 64'h50);
    step();
    step();
    drive2(2'b01, 5'd6, 5'd0, 64'h60, 64'h0);
    step();
    idle();
    checks++;
    if (count !== 4'd5) begin
      failures++;
      $display("FAIL mid_fill got=%0d exp=5", count);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || count !== 4'd0) begin
      failures++;
      $display("FAIL mid_reset got=%b/%0d exp=0/0",
               out_valid, count);
    end
    checks++;
    if (out_address !== '0 || out_data !== '0 ||
        out_coreid !== '0) begin
      failures++;
      $display("FAIL mid_out got=%h/%h/%h exp=0",
               out_address, out_data, out_coreid);
    end
    step();
    reset = 1'b1;
    drive2(2'b01, 5'd9, 5'd0, 64'h55, 64'h0);
    step();
    idle();
    checks++;
    if (count !== 4'd1 || out_address !== 5'd9 ||
        out_data !== 64'h55) begin
      failures++;
      $display("FAIL first_push got=%0d/%0d/%h exp=1/9/55",
               count, out_address, out_data);
    end
  endtask

  initial begin
    test_reset();
    test_order();
    test_skip_zero();
    test_overflow();
    test_wrap();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
